shift_reg_arbiter: RTL

Serialiser and arbiter that shares one parallel-load shift register between two requesters. Each accepted word is loaded into the register and shifted out MSB-first, one bit per clock, on a single serial output. Grants alternate round-robin when both requesters are waiting. The block sits between word-level producers and a one-bit serial link in the gate-level teaching designs.

---
 rtl/shift_arb_pkg.sv | 16 +
 rtl/shift_reg_core.sv | 27 ++
 rtl/shift_reg_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and helpers for the two-requester serialising arbiter.
package shift_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic src_t;

    // Bits needed to hold WIDTH-1; never narrower than one bit.
    function automatic int unsigned count_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_reg_core.sv
// Parallel-load, MSB-first shift register; load wins over shift.
module shift_reg_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] sreg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load) begin
            sreg_q <= din;
        end else if (shift) begin
            sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
        end
    end

    assign msb = sreg_q[WIDTH-1];

endmodule

// File: rtl/shift_reg_arbiter.sv
// Round-robin arbiter sharing one shift register between two word producers,
// serialising each accepted word MSB-first onto a one-bit link.
module shift_reg_arbiter
    import shift_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             sout_src,
    output logic             busy
);

    localparam int unsigned CntW = count_width(WIDTH);

    state_t            state_q, state_d;
    logic [CntW-1:0]   count_q, count_d;
    src_t              prio_q, prio_d;
    src_t              src_q, src_d;
    src_t              grant;
    logic              accept;
    logic              msb;
    logic [WIDTH-1:0]  load_data;

    always_comb begin
        grant = prio_q;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    // Readys are gated by rst so nothing is offered while reset is held.
    assign req0_ready = !rst && (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = !rst && (state_q == IDLE) && req1_valid && (grant == 1'b1);
    assign accept     = req0_ready || req1_ready;
    assign load_data  = grant ? req1_data : req0_data;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prio_d  = prio_q;
        src_d   = src_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    count_d = CntW'(WIDTH - 1);
                    src_d   = grant;
                    prio_d  = ~grant;
                end
            end
            SHIFT: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q - CntW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            prio_q  <= 1'b0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prio_q  <= prio_d;
            src_q   <= src_d;
        end
    end

    shift_reg_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state_q == SHIFT),
        .din   (load_data),
        .msb   (msb)
    );

    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    assign sout       = busy && msb;
    assign sout_last  = busy && (count_q == '0);
    assign sout_src   = src_q;

endmodule
